// File: rtl/metro_gate_ctrl.sv
// rtl/metro_gate_ctrl.sv - access-gate controller: code range check, timed door, lockout, emergency override
module metro_gate_ctrl #(
   parameter int CODE_W         = 4,
   parameter int CODE_MIN       = 4,
   parameter int CODE_MAX       = 11,
   parameter int OPEN_CYCLES    = 8,
   parameter int LOCKOUT_CYCLES = 16,
   parameter int TMR_W          = 5,
   parameter int MAX_FAILS      = 3,
   parameter int FAIL_W         = 2,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              validate_code,
   input  logic [CODE_W-1:0] access_code,
   input  logic              pass_sensor,
   input  logic              emergency,
   output logic              opendoor,
   output logic              deny,
   output logic              locked,
   output logic [FAIL_W-1:0] fail_count,
   output logic [CNT_W-1:0]  pass_count,
   output logic [2:0]        state_out
);

   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      CHECK   = 3'b001,
      GRANT   = 3'b010,
      DENIED  = 3'b011,
      LOCKOUT = 3'b100,
      EMERG   = 3'b101
   } state_t;

   // Bounds and terminal timer values sized to the registers they are compared with
   localparam logic [CODE_W-1:0] CODE_LO    = CODE_W'(CODE_MIN);
   localparam logic [CODE_W-1:0] CODE_HI    = CODE_W'(CODE_MAX);
   localparam logic [TMR_W-1:0]  OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0]  LOCK_LAST  = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAILS);

   state_t              state;
   state_t              state_next;
   logic [CODE_W-1:0]   code_reg;
   logic [CODE_W-1:0]   code_next;
   logic [TMR_W-1:0]    timer;
   logic [TMR_W-1:0]    timer_next;
   logic [FAIL_W-1:0]   fail_next;
   logic [CNT_W-1:0]    pass_next;
   logic                code_ok;
   logic                grant_done;
   logic                lock_done;

   // Range check always uses the captured code, never the live input
   assign code_ok    = (code_reg >= CODE_LO) && (code_reg <= CODE_HI);
   assign grant_done = pass_sensor || (timer == OPEN_LAST);
   assign lock_done  = (timer == LOCK_LAST);

   // Next-state selection; emergency overrides every other transition
   always_comb begin
      state_next = state;
      if (emergency) begin
         state_next = EMERG;
      end else begin
         case (state)
            IDLE:    if (validate_code) state_next = CHECK;
            CHECK:   state_next = code_ok ? GRANT : DENIED;
            DENIED:  state_next = (fail_count == FAIL_LIMIT) ? LOCKOUT : IDLE;
            GRANT:   if (grant_done) state_next = IDLE;
            LOCKOUT: if (lock_done) state_next = IDLE;
            EMERG:   state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Dwell timer runs only while staying in GRANT or LOCKOUT, zero otherwise
   always_comb begin
      timer_next = '0;
      if ((state_next == state) && ((state == GRANT) || (state == LOCKOUT))) begin
         timer_next = timer + TMR_W'(1);
      end
   end

   // Code capture, failure and passage bookkeeping; all frozen when emergency is asserted
   always_comb begin
      code_next = code_reg;
      fail_next = fail_count;
      pass_next = pass_count;
      if (!emergency) begin
         case (state)
            IDLE: begin
               if (validate_code) code_next = access_code;
            end
            CHECK: begin
               if (code_ok) begin
                  fail_next = '0;
                  if (pass_count != '1) pass_next = pass_count + CNT_W'(1);
               end else if (fail_count != '1) begin
                  fail_next = fail_count + FAIL_W'(1);
               end
            end
            LOCKOUT: begin
               if (lock_done) fail_next = '0;
            end
            EMERG: begin
               fail_next = '0;
            end
            default: begin
            end
         endcase
      end
   end

   // State and counter registers with asynchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         code_reg   <= '0;
         timer      <= '0;
         fail_count <= '0;
         pass_count <= '0;
      end else begin
         state      <= state_next;
         code_reg   <= code_next;
         timer      <= timer_next;
         fail_count <= fail_next;
         pass_count <= pass_next;
      end
   end

   // Outputs are pure decodes of the registered state
   always_comb begin
      opendoor  = (state == GRANT) || (state == EMERG);
      deny      = (state == DENIED);
      locked    = (state == LOCKOUT);
      state_out = state;
   end

endmodule

// File: doc/metro_gate_ctrl.md
Name: metro_gate_ctrl

Overview:
Parametrised access-gate controller, the successor to the single-gate metro FSM. It captures a submitted access code and checks it against a programmable valid range. On a valid code it opens the door for a bounded time, which ends early once the passenger-pass sensor fires. Repeated failures trigger a timed lockout, and an emergency override forces the door open; a passage counter feeds station statistics logic.

Parameters:
CODE_W, 4, access code width in bits
CODE_MIN, 4, lowest valid code (inclusive, unsigned)
CODE_MAX, 11, highest valid code (inclusive, unsigned); CODE_MIN <= CODE_MAX < 2^CODE_W
OPEN_CYCLES, 8, cycles door stays open in GRANT absent pass_sensor; 1..2^TMR_W
LOCKOUT_CYCLES, 16, cycles spent in LOCKOUT; 1..2^TMR_W
TMR_W, 5, width of the shared dwell timer
MAX_FAILS, 3, consecutive failures that trigger lockout; 1..2^FAIL_W-1
FAIL_W, 2, failure counter width
CNT_W, 16, passage counter width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
validate_code  input  1  code submission strobe, sampled in IDLE only
access_code  input  CODE_W  code presented with validate_code
pass_sensor  input  1  passenger passed through; used in GRANT only
emergency  input  1  level, forces door open while high
opendoor  output  1  door open command
deny  output  1  one-cycle reject indication
locked  output  1  high while in LOCKOUT
fail_count  output  FAIL_W  current consecutive-failure count
pass_count  output  CNT_W  granted passages, saturating
state_out  output  3  current state encoding

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (reset_n). Reset puts the state in IDLE and zeroes code_reg, timer, fail_count and pass_count. Therefore opendoor=0, deny=0, locked=0 and state_out=3'b000 immediately on reset assertion.
- State encodings: IDLE=000, CHECK=001, GRANT=010, DENY=011, LOCKOUT=100, EMERG=101. Unused codes go to IDLE on the next edge.
- All outputs are decoded from registered state/counters only; there is no input-to-output combinational path.
  - opendoor = (GRANT or EMERG)
  - deny = DENY
  - locked = LOCKOUT
- Priority: emergency=1 sends the next state to EMERG from any state, overriding all other transitions. The timer is cleared and fail_count is unchanged.
- EMERG: stays while emergency=1. On emergency=0 it goes to IDLE, and fail_count clears on that exit edge.
- IDLE: on validate_code=1, capture access_code into code_reg at the same edge and go to CHECK. Otherwise stay.
- CHECK (exactly 1 cycle): compare code_reg, never the live input.
  - CODE_MIN <= code_reg <= CODE_MAX: go to GRANT, clear fail_count, increment pass_count (saturating at all-ones).
  - Otherwise: go to DENY, fail_count+1 (saturating).
- DENY (exactly 1 cycle): if fail_count == MAX_FAILS, go to LOCKOUT; else go to IDLE.
- GRANT: timer counts from 0, incrementing each cycle in GRANT.
  - Exit to IDLE when pass_sensor=1 or timer == OPEN_CYCLES-1, whichever comes first.
  - Door is open for at most OPEN_CYCLES cycles, minimum 1.
- LOCKOUT: timer counts from 0. Exit to IDLE when timer == LOCKOUT_CYCLES-1, clearing fail_count on that edge. validate_code is ignored.
- Timer: cleared on every state change and in IDLE, CHECK, DENY and EMERG. It never wraps within a dwell, because of the parameter limits.
- Ignored inputs: validate_code in any state other than IDLE is ignored, with no queuing. pass_sensor outside GRANT is ignored.
- Latency: validate edge to opendoor high = 2 cycles (IDLE->CHECK->GRANT). Validate to deny = 2 cycles.
- Reset mid-GRANT/LOCKOUT: the door closes immediately (asynchronously) and all counters zero.

Test Plan:
- Reset, then validate_code=1 with code=4 for 1 cycle. Required: CHECK, then GRANT with opendoor=1 for exactly 8 cycles, then IDLE; pass_count=1, fail_count=0.
- Valid code 11, pass_sensor=1 on the 3rd GRANT cycle. Required: opendoor high for exactly 3 cycles, IDLE next.
- Code 3, then 12, then 15, each submitted from IDLE. Required: deny pulses 1 cycle each; fail_count goes 1,2,3. After the third DENY, locked=1 for exactly 16 cycles, during which a validate with code 5 is ignored; then IDLE with fail_count=0.
- Two failures (fail_count=2), then valid code 7. Required: fail_count clears to 0 when leaving CHECK; GRANT entered.
- emergency=1 during LOCKOUT cycle 5, held 4 cycles. Required: EMERG (state_out=101), opendoor=1; after release IDLE, locked=0, fail_count=0.
- reset_n low mid-GRANT cycle 4 (asynchronous, between edges). Required: opendoor=0 and state_out=000 immediately; pass_count=0.
